// File: rtl/stack_pkg.sv
// Shared constants for the operand stack: default geometry, internal
// operation encoding and the controller's instruction opcodes.
package stack_pkg;
    localparam int WIDTH_DEF = 8;
    localparam int DEPTH_DEF = 16;

    typedef logic [2:0] op_t;
    localparam op_t OP_IDLE = 3'd0;
    localparam op_t OP_PUSH = 3'd1;
    localparam op_t OP_POP  = 3'd2;
    localparam op_t OP_TOS  = 3'd3;
    localparam op_t OP_REPL = 3'd4;

    localparam logic [2:0] PUSH = 3'b100;
    localparam logic [2:0] POP  = 3'b101;
    localparam logic [2:0] J    = 3'b110;
    localparam logic [2:0] JZ   = 3'b111;
endpackage

// File: rtl/stack_op_decode.sv
// Collapses the controller strobes into a single stack operation per cycle,
// with push/pop/tos priority and the overflow/underflow error strobes.
module stack_op_decode
    import stack_pkg::*;
(
    input  logic push_i,
    input  logic pop_i,
    input  logic tos_i,
    input  logic empty_i,
    input  logic full_i,
    output op_t  op_o,
    output logic err_ovf_o,
    output logic err_unf_o
);
    always_comb begin
        op_o      = OP_IDLE;
        err_ovf_o = 1'b0;
        err_unf_o = 1'b0;
        if (push_i && pop_i) begin
            // Replace on an empty stack degrades to a push but still flags the missing top.
            if (empty_i) begin
                op_o      = OP_PUSH;
                err_unf_o = 1'b1;
            end else begin
                op_o = OP_REPL;
            end
        end else if (push_i) begin
            if (full_i) err_ovf_o = 1'b1;
            else        op_o      = OP_PUSH;
        end else if (pop_i) begin
            if (empty_i) err_unf_o = 1'b1;
            else         op_o      = OP_POP;
        end else if (tos_i) begin
            if (empty_i) err_unf_o = 1'b1;
            else         op_o      = OP_TOS;
        end
    end
endmodule

// File: rtl/stack_unit.sv
// Operand stack for the multicycle stack CPU: flop-array storage, registered
// pop/peek output, occupancy and sticky error flags.
module stack_unit
    import stack_pkg::*;
#(
    parameter  int WIDTH = WIDTH_DEF,
    parameter  int DEPTH = DEPTH_DEF,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             tos,
    input  logic             stack_sel,
    input  logic [WIDTH-1:0] mem_data,
    input  logic [WIDTH-1:0] alu_data,
    output logic [WIDTH-1:0] dout,
    output logic [PTR_W:0]   count,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow,
    input  logic             err_clr
);
    logic [DEPTH-1:0][WIDTH-1:0] mem_q;
    logic [PTR_W:0]              count_q, count_d;
    logic [WIDTH-1:0]            dout_q, dout_d;
    logic                        ovf_q, ovf_d, unf_q, unf_d;
    logic [WIDTH-1:0]            push_data, top_data;
    logic [PTR_W-1:0]            top_idx, wr_idx;
    logic                        wr_en, err_ovf, err_unf;
    op_t                         op;

    assign empty     = (count_q == '0);
    assign full      = (count_q == (PTR_W+1)'(DEPTH));
    assign push_data = stack_sel ? mem_data : alu_data;
    assign top_idx   = PTR_W'(count_q - 1'b1);
    assign top_data  = mem_q[top_idx];

    stack_op_decode u_dec (
        .push_i    (push),
        .pop_i     (pop),
        .tos_i     (tos),
        .empty_i   (empty),
        .full_i    (full),
        .op_o      (op),
        .err_ovf_o (err_ovf),
        .err_unf_o (err_unf)
    );

    always_comb begin
        count_d = count_q;
        dout_d  = dout_q;
        wr_en   = 1'b0;
        wr_idx  = count_q[PTR_W-1:0];
        case (op)
            OP_PUSH: begin
                wr_en   = 1'b1;
                count_d = count_q + 1'b1;
            end
            OP_POP: begin
                dout_d  = top_data;
                count_d = count_q - 1'b1;
            end
            OP_TOS:  dout_d = top_data;
            OP_REPL: begin
                dout_d = top_data;
                wr_en  = 1'b1;
                wr_idx = top_idx;
            end
            default: ;
        endcase
        // A new error in the same cycle as err_clr must stay visible.
        ovf_d = err_ovf | (ovf_q & ~err_clr);
        unf_d = err_unf | (unf_q & ~err_clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q   <= '0;
            count_q <= '0;
            dout_q  <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            if (wr_en) mem_q[wr_idx] <= push_data;
            count_q <= count_d;
            dout_q  <= dout_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign dout      = dout_q;
    assign count     = count_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;
endmodule

// File: tb/tb_stack_unit.sv
// Scoreboard bench for stack_unit: directed scenarios plus random traffic,
// checked against a queue-based stack model.
module tb_stack_unit;
    logic       clk, rst, push, pop, tos, stack_sel, err_clr;
    logic [7:0] mem_data, alu_data, dout;
    logic [4:0] count;
    logic       empty, full, overflow, underflow;

    typedef struct {
        logic [7:0] dout;
        logic [4:0] count;
        logic       ovf;
        logic       unf;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] m_stk[$];
    logic [7:0] m_dout;
    logic       m_ovf, m_unf;
    int         errors = 0;
    int         checks = 0;

    stack_unit dut (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .tos(tos),
        .stack_sel(stack_sel), .mem_data(mem_data), .alu_data(alu_data),
        .dout(dout), .count(count), .empty(empty), .full(full),
        .overflow(overflow), .underflow(underflow), .err_clr(err_clr)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("dout",      dout,      e.dout);
            chk("count",     count,     e.count);
            chk("empty",     empty,     e.count == 0);
            chk("full",      full,      e.count == 16);
            chk("overflow",  overflow,  e.ovf);
            chk("underflow", underflow, e.unf);
        end
    end

    // One clock of stimulus; model updated from the stack rules, expectation queued after the edge.
    task automatic step(input logic pu, po, to, sel, input logic [7:0] md, ad, input logic clr);
        logic [7:0] d;
        bit so, su;
        exp_t e;
        push = pu; pop = po; tos = to; stack_sel = sel;
        mem_data = md; alu_data = ad; err_clr = clr;
        d = sel ? md : ad;
        so = 0; su = 0;
        if (pu && po) begin
            if (m_stk.size() == 0) begin m_stk.push_back(d); su = 1; end
            else begin m_dout = m_stk[m_stk.size()-1]; m_stk[m_stk.size()-1] = d; end
        end else if (pu) begin
            if (m_stk.size() == 16) so = 1;
            else m_stk.push_back(d);
        end else if (po) begin
            if (m_stk.size() == 0) su = 1;
            else m_dout = m_stk.pop_back();
        end else if (to) begin
            if (m_stk.size() == 0) su = 1;
            else m_dout = m_stk[m_stk.size()-1];
        end
        m_ovf = so ? 1'b1 : (clr ? 1'b0 : m_ovf);
        m_unf = su ? 1'b1 : (clr ? 1'b0 : m_unf);
        @(posedge clk); #1;
        e.dout = m_dout; e.count = 5'(m_stk.size()); e.ovf = m_ovf; e.unf = m_unf;
        sb.push_back(e);
        push = 0; pop = 0; tos = 0; err_clr = 0;
    endtask

    task automatic do_push(input logic [7:0] v);
        step(1, 0, 0, 1, v, 8'h5A, 0);
    endtask

    task automatic do_pop();
        step(0, 1, 0, 0, 8'h00, 8'h00, 0);
    endtask

    initial begin
        rst = 1; push = 0; pop = 0; tos = 0; stack_sel = 0; err_clr = 0;
        mem_data = 0; alu_data = 0;
        m_dout = 0; m_ovf = 0; m_unf = 0;
        #12;
        chk("rst_count", count, 0);
        chk("rst_dout", dout, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_flags", {overflow, underflow}, 0);
        @(posedge clk); #1 rst = 0;

        do_push(8'h11); do_push(8'h22); do_push(8'h33);
        do_pop(); do_pop(); do_pop();

        step(1, 0, 0, 0, 8'hFF, 8'hA5, 0);
        step(0, 0, 1, 0, 8'h00, 8'h00, 0);
        step(0, 0, 1, 0, 8'h00, 8'h00, 0);
        do_pop();

        for (int i = 0; i < 16; i++) do_push(8'(i));
        do_push(8'hEE);
        for (int i = 0; i < 16; i++) do_pop();

        do_pop();
        step(0, 0, 0, 0, 8'h00, 8'h00, 1);
        step(0, 1, 0, 0, 8'h00, 8'h00, 1);

        do_push(8'h10); do_push(8'h20);
        step(1, 1, 0, 0, 8'h99, 8'h30, 0);
        do_pop(); do_pop();

        do_push(8'h41); do_push(8'h42); do_push(8'h43);
        @(negedge clk); #2;
        rst = 1;
        #1;
        chk("arst_count", count, 0);
        chk("arst_dout", dout, 0);
        chk("arst_empty", empty, 1);
        chk("arst_flags", {overflow, underflow}, 0);
        m_stk.delete(); m_dout = 0; m_ovf = 0; m_unf = 0;
        @(posedge clk); #1 rst = 0;
        do_pop();

        for (int n = 0; n < 600; n++)
            step($urandom_range(0, 99) < 45, $urandom_range(0, 99) < 35,
                 $urandom_range(0, 99) < 25, 1'($urandom), 8'($urandom), 8'($urandom),
                 $urandom_range(0, 99) < 5);

        @(negedge clk); #1;
        chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
